// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if
//   Bundles the entry, control, forwarding and observation signals of
//   pipe_stage_chain. The signal names match the flat ports of the original
//   block, so the code on either side of the interface reads the same as before.
//   master : the upstream side. It drives the entry, stall/flush and the forwarding queries.
//   slave  : the pipe_stage_chain side. It drives the stage outputs, the forwarding
//            results, occupancy and the counters.
interface pipe_stage_chain_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned SW    = $clog2(STAGES);
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic              in_valid;
    logic [DATA_W-1:0] in_payload;
    logic [RD_W-1:0]   in_rd;
    logic              in_wen;
    logic              stall;
    logic              flush;
    logic [RD_W-1:0]   fwd_rs1;
    logic [RD_W-1:0]   fwd_rs2;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;
    logic [SW-1:0]     fwd1_stage;
    logic [SW-1:0]     fwd2_stage;
    logic              out_valid;
    logic [DATA_W-1:0] out_payload;
    logic [RD_W-1:0]   out_rd;
    logic              out_wen;
    logic [STAGES-1:0] stage_valid;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output in_valid, in_payload, in_rd, in_wen, stall, flush, fwd_rs1, fwd_rs2,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, fwd1_stage, fwd2_stage,
        input  out_valid, out_payload, out_rd, out_wen, stage_valid, occupancy,
        input  bubble_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_payload, in_rd, in_wen, stall, flush, fwd_rs1, fwd_rs2,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, fwd1_stage, fwd2_stage,
        output out_valid, out_payload, out_rd, out_wen, stage_valid, occupancy,
        output bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   A generic chain of STAGES pipeline registers. Each stage holds valid,
//   payload, rd and wen. Stage 0 is the youngest stage and STAGES-1 is the
//   oldest, which drives out_*.
//   A stall holds stages 0..HOLD-1 and inserts a bubble at stage HOLD.
//   A flush squashes stages 0..FLUSH-1 and takes priority over a stall.
//   The block also provides a youngest-first forwarding lookup for two
//   source registers, a popcount occupancy and saturating bubble/flush
//   counters.
// Ports:
//   clk   rising-edge clock
//   reset synchronous, active-high; has priority over stall and flush
//   bus   pipe_stage_chain_if.slave: entry inputs, stall/flush, forwarding
//         queries/results, stage outputs, occupancy and counters
module pipe_stage_chain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned STAGES = 4,
    parameter int unsigned HOLD   = 1,
    parameter int unsigned FLUSH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_stage_chain_if.slave bus
);
    localparam int unsigned SW    = $clog2(STAGES);
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q, v_d, wen_q, wen_d;
    logic [DATA_W-1:0] pay_q [STAGES];
    logic [DATA_W-1:0] pay_d [STAGES];
    logic [RD_W-1:0]   rd_q  [STAGES];
    logic [RD_W-1:0]   rd_d  [STAGES];
    logic [CNT_W-1:0]  bubble_q, flush_q;

    // Next-state logic. The normal shift is computed first. Flush or stall
    // then overrides the young stages, so the stages above the override point
    // always shift unchanged.
    always_comb begin
        if (bus.in_valid) begin
            v_d[0]   = 1'b1;
            wen_d[0] = bus.in_wen;
            pay_d[0] = bus.in_payload;
            rd_d[0]  = bus.in_rd;
        end else begin
            v_d[0]   = 1'b0;
            wen_d[0] = 1'b0;
            pay_d[0] = '0;
            rd_d[0]  = '0;
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_d[k]   = v_q[k-1];
            wen_d[k] = wen_q[k-1];
            pay_d[k] = pay_q[k-1];
            rd_d[k]  = rd_q[k-1];
        end
        if (bus.flush) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (k < FLUSH) begin
                    v_d[k]   = 1'b0;
                    wen_d[k] = 1'b0;
                    pay_d[k] = '0;
                    rd_d[k]  = '0;
                end
            end
        end else if (bus.stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (k < HOLD) begin
                    v_d[k]   = v_q[k];
                    wen_d[k] = wen_q[k];
                    pay_d[k] = pay_q[k];
                    rd_d[k]  = rd_q[k];
                end else if (k == HOLD) begin
                    v_d[k]   = 1'b0;
                    wen_d[k] = 1'b0;
                    pay_d[k] = '0;
                    rd_d[k]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q      <= '0;
            wen_q    <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                pay_q[k] <= '0;
                rd_q[k]  <= '0;
            end
        end else begin
            v_q   <= v_d;
            wen_q <= wen_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                pay_q[k] <= pay_d[k];
                rd_q[k]  <= rd_d[k];
            end
            if (bus.flush) begin
                if (flush_q != '1) flush_q <= flush_q + 1'b1;
            end else if (bus.stall) begin
                if (bubble_q != '1) bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    // Forwarding lookup. The scan runs upward and keeps the first match it
    // finds, so the youngest matching stage wins. Register 0 never matches.
    logic              hit1, hit2;
    logic [DATA_W-1:0] data1, data2;
    logic [SW-1:0]     stg1, stg2;

    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        stg1  = '0;
        stg2  = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (!hit1 && v_q[k] && wen_q[k] && (rd_q[k] == bus.fwd_rs1) && (bus.fwd_rs1 != '0)) begin
                hit1  = 1'b1;
                data1 = pay_q[k];
                stg1  = SW'(k);
            end
            if (!hit2 && v_q[k] && wen_q[k] && (rd_q[k] == bus.fwd_rs2) && (bus.fwd_rs2 != '0)) begin
                hit2  = 1'b1;
                data2 = pay_q[k];
                stg2  = SW'(k);
            end
        end
    end

    logic [OCC_W-1:0] occ;

    always_comb begin
        occ = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occ = occ + OCC_W'(v_q[k]);
        end
    end

    assign bus.fwd1_hit    = hit1;
    assign bus.fwd2_hit    = hit2;
    assign bus.fwd1_data   = data1;
    assign bus.fwd2_data   = data2;
    assign bus.fwd1_stage  = stg1;
    assign bus.fwd2_stage  = stg2;
    assign bus.out_valid   = v_q[STAGES-1];
    assign bus.out_payload = pay_q[STAGES-1];
    assign bus.out_rd      = rd_q[STAGES-1];
    assign bus.out_wen     = wen_q[STAGES-1];
    assign bus.stage_valid = v_q;
    assign bus.occupancy   = occ;
    assign bus.bubble_cnt  = bubble_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
//   Directed bench for pipe_stage_chain. The main DUT uses the default
//   parameters. A second DUT with CNT_W=2 exercises counter saturation.
//   Inputs change 1 time unit after a rising edge, and outputs are sampled
//   at that same point.
module tb_pipe_stage_chain;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.DATA_W(32), .RD_W(5), .STAGES(4), .CNT_W(16)) bus_a ();
    pipe_stage_chain_if #(.DATA_W(32), .RD_W(5), .STAGES(4), .CNT_W(2))  bus_b ();

    pipe_stage_chain #(.DATA_W(32), .RD_W(5), .STAGES(4), .HOLD(1), .FLUSH(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    pipe_stage_chain #(.DATA_W(32), .RD_W(5), .STAGES(4), .HOLD(1), .FLUSH(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.in_valid = 0; bus_a.in_payload = '0; bus_a.in_rd = '0; bus_a.in_wen = 0;
        bus_a.stall = 0; bus_a.flush = 0; bus_a.fwd_rs1 = '0; bus_a.fwd_rs2 = '0;
        bus_b.in_valid = 0; bus_b.in_payload = '0; bus_b.in_rd = '0; bus_b.in_wen = 0;
        bus_b.stall = 0; bus_b.flush = 0; bus_b.fwd_rs1 = '0; bus_b.fwd_rs2 = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic push(input logic [31:0] p, input logic [4:0] r, input logic w);
        bus_a.in_valid = 1; bus_a.in_payload = p; bus_a.in_rd = r; bus_a.in_wen = w;
        tick();
        bus_a.in_valid = 0; bus_a.in_payload = '0; bus_a.in_rd = '0; bus_a.in_wen = 0;
    endtask

    task automatic test_reset();
        do_reset();
        bus_a.fwd_rs1 = 5'd3;
        #1;
        checks++; if (bus_a.stage_valid !== 4'b0000) begin errors++; $display("FAIL rst_stage_valid: got %b want 0000", bus_a.stage_valid); end
        checks++; if (bus_a.occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy: got %0d want 0", bus_a.occupancy); end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus_a.out_valid); end
        checks++; if (bus_a.bubble_cnt !== 16'd0) begin errors++; $display("FAIL rst_bubble_cnt: got %0d want 0", bus_a.bubble_cnt); end
        checks++; if (bus_a.flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d want 0", bus_a.flush_cnt); end
        checks++; if (bus_a.fwd1_hit !== 1'b0) begin errors++; $display("FAIL rst_fwd1_hit: got %b want 0", bus_a.fwd1_hit); end
    endtask

    task automatic test_latency();
        do_reset();
        bus_a.fwd_rs1 = 5'd3;
        push(32'h11, 5'd3, 1'b1);   // edge 1
        checks++; if (bus_a.fwd1_hit !== 1'b1 || bus_a.fwd1_data !== 32'h11 || bus_a.fwd1_stage !== 2'd0) begin
            errors++; $display("FAIL lat_fwd_s0: got hit=%b data=%0h stage=%0d want 1/11/0", bus_a.fwd1_hit, bus_a.fwd1_data, bus_a.fwd1_stage); end
        for (int e = 1; e <= 3; e++) begin
            checks++; if (bus_a.occupancy !== 3'd1 || bus_a.out_valid !== 1'b0) begin
                errors++; $display("FAIL lat_edge%0d: got occ=%0d out_valid=%b want 1/0", e, bus_a.occupancy, bus_a.out_valid); end
            if (e == 2) begin
                checks++; if (bus_a.fwd1_stage !== 2'd1) begin errors++; $display("FAIL lat_fwd_s1: got %0d want 1", bus_a.fwd1_stage); end
            end
            tick();
        end
        // after edge 4
        checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_payload !== 32'h11 || bus_a.out_rd !== 5'd3 || bus_a.out_wen !== 1'b1) begin
            errors++; $display("FAIL lat_out: got v=%b p=%0h rd=%0d w=%b want 1/11/3/1", bus_a.out_valid, bus_a.out_payload, bus_a.out_rd, bus_a.out_wen); end
        checks++; if (bus_a.occupancy !== 3'd1) begin errors++; $display("FAIL lat_occ4: got %0d want 1", bus_a.occupancy); end
        tick();
        checks++; if (bus_a.occupancy !== 3'd0 || bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL lat_drop: got occ=%0d out_valid=%b want 0/0", bus_a.occupancy, bus_a.out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            bus_a.in_valid = 1; bus_a.in_payload = 32'(k); bus_a.in_rd = 5'(k); bus_a.in_wen = 1;
            tick();
            if (k >= 4) begin
                checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_payload !== 32'(k - 3)) begin
                    errors++; $display("FAIL b2b_out%0d: got v=%b p=%0h want 1/%0h", k, bus_a.out_valid, bus_a.out_payload, k - 3); end
            end
        end
        checks++; if (bus_a.occupancy !== 3'd4 || bus_a.stage_valid !== 4'b1111) begin
            errors++; $display("FAIL b2b_full: got occ=%0d sv=%b want 4/1111", bus_a.occupancy, bus_a.stage_valid); end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        push(32'h33, 5'd2, 1'b1);   // Y
        push(32'h22, 5'd1, 1'b1);   // X
        bus_a.stall = 1;
        bus_a.in_valid = 1; bus_a.in_payload = 32'h44; bus_a.in_rd = 5'd4; bus_a.in_wen = 1;
        tick();
        idle();
        bus_a.fwd_rs1 = 5'd1; bus_a.fwd_rs2 = 5'd2;
        #1;
        checks++; if (bus_a.stage_valid !== 4'b0101) begin errors++; $display("FAIL stall_sv: got %b want 0101", bus_a.stage_valid); end
        checks++; if (bus_a.bubble_cnt !== 16'd1 || bus_a.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL stall_cnt: got b=%0d f=%0d want 1/0", bus_a.bubble_cnt, bus_a.flush_cnt); end
        checks++; if (bus_a.fwd1_hit !== 1'b1 || bus_a.fwd1_data !== 32'h22 || bus_a.fwd1_stage !== 2'd0) begin
            errors++; $display("FAIL stall_x: got hit=%b data=%0h stage=%0d want 1/22/0", bus_a.fwd1_hit, bus_a.fwd1_data, bus_a.fwd1_stage); end
        checks++; if (bus_a.fwd2_hit !== 1'b1 || bus_a.fwd2_data !== 32'h33 || bus_a.fwd2_stage !== 2'd2) begin
            errors++; $display("FAIL stall_y: got hit=%b data=%0h stage=%0d want 1/33/2", bus_a.fwd2_hit, bus_a.fwd2_data, bus_a.fwd2_stage); end
        bus_a.fwd_rs1 = 5'd4;
        #1;
        checks++; if (bus_a.fwd1_hit !== 1'b0) begin errors++; $display("FAIL stall_ignored_in: got hit=%b want 0", bus_a.fwd1_hit); end
        tick();
        checks++; if (bus_a.stage_valid !== 4'b1010 || bus_a.out_payload !== 32'h33) begin
            errors++; $display("FAIL stall_shift: got sv=%b p=%0h want 1010/33", bus_a.stage_valid, bus_a.out_payload); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        push(32'h0C, 5'd6, 1'b1);   // C
        push(32'h0B, 5'd7, 1'b1);   // B
        push(32'h0A, 5'd8, 1'b1);   // A
        bus_a.flush = 1; bus_a.stall = 1;
        bus_a.in_valid = 1; bus_a.in_payload = 32'hDD; bus_a.in_rd = 5'd9; bus_a.in_wen = 1;
        tick();
        idle();
        bus_a.fwd_rs1 = 5'd7; bus_a.fwd_rs2 = 5'd8;
        #1;
        checks++; if (bus_a.stage_valid !== 4'b1100) begin errors++; $display("FAIL flush_sv: got %b want 1100", bus_a.stage_valid); end
        checks++; if (bus_a.flush_cnt !== 16'd1 || bus_a.bubble_cnt !== 16'd0) begin
            errors++; $display("FAIL flush_cnt: got f=%0d b=%0d want 1/0", bus_a.flush_cnt, bus_a.bubble_cnt); end
        checks++; if (bus_a.out_payload !== 32'h0C || bus_a.out_rd !== 5'd6) begin
            errors++; $display("FAIL flush_s3: got p=%0h rd=%0d want 0c/6", bus_a.out_payload, bus_a.out_rd); end
        checks++; if (bus_a.fwd1_hit !== 1'b1 || bus_a.fwd1_data !== 32'h0B || bus_a.fwd1_stage !== 2'd2) begin
            errors++; $display("FAIL flush_s2: got hit=%b data=%0h stage=%0d want 1/0b/2", bus_a.fwd1_hit, bus_a.fwd1_data, bus_a.fwd1_stage); end
        checks++; if (bus_a.fwd2_hit !== 1'b0 || bus_a.fwd2_data !== 32'h0 || bus_a.fwd2_stage !== 2'd0) begin
            errors++; $display("FAIL flush_a_gone: got hit=%b data=%0h stage=%0d want 0/0/0", bus_a.fwd2_hit, bus_a.fwd2_data, bus_a.fwd2_stage); end
    endtask

    task automatic test_forwarding();
        do_reset();
        push(32'hBB, 5'd5, 1'b1);
        push(32'hAA, 5'd5, 1'b1);
        push(32'h99, 5'd0, 1'b1);
        bus_a.fwd_rs1 = 5'd5; bus_a.fwd_rs2 = 5'd0;
        #1;
        checks++; if (bus_a.fwd1_hit !== 1'b1 || bus_a.fwd1_data !== 32'hAA || bus_a.fwd1_stage !== 2'd1) begin
            errors++; $display("FAIL fwd_youngest: got hit=%b data=%0h stage=%0d want 1/aa/1", bus_a.fwd1_hit, bus_a.fwd1_data, bus_a.fwd1_stage); end
        checks++; if (bus_a.fwd2_hit !== 1'b0 || bus_a.fwd2_data !== 32'h0 || bus_a.fwd2_stage !== 2'd0) begin
            errors++; $display("FAIL fwd_r0: got hit=%b data=%0h stage=%0d want 0/0/0", bus_a.fwd2_hit, bus_a.fwd2_data, bus_a.fwd2_stage); end
        do_reset();
        push(32'hBB, 5'd5, 1'b1);
        push(32'hAA, 5'd5, 1'b0);
        push(32'h99, 5'd0, 1'b1);
        bus_a.fwd_rs1 = 5'd5; bus_a.fwd_rs2 = 5'd0;
        #1;
        checks++; if (bus_a.fwd1_hit !== 1'b1 || bus_a.fwd1_data !== 32'hBB || bus_a.fwd1_stage !== 2'd2) begin
            errors++; $display("FAIL fwd_skip_nowen: got hit=%b data=%0h stage=%0d want 1/bb/2", bus_a.fwd1_hit, bus_a.fwd1_data, bus_a.fwd1_stage); end
    endtask

    task automatic test_saturate();
        do_reset();
        bus_b.stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus_b.bubble_cnt !== 2'((i < 3) ? i + 1 : 3)) begin
                errors++; $display("FAIL sat_bubble%0d: got %0d want %0d", i, bus_b.bubble_cnt, (i < 3) ? i + 1 : 3); end
        end
        bus_b.stall = 0;
        checks++; if (bus_b.flush_cnt !== 2'd0) begin errors++; $display("FAIL sat_flush: got %0d want 0", bus_b.flush_cnt); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        bus_a.stall = 1; tick(); bus_a.stall = 0;
        bus_a.flush = 1; tick(); bus_a.flush = 0;
        for (int k = 0; k < 4; k++) push(32'(k + 'h50), 5'(k + 1), 1'b1);
        checks++; if (bus_a.stage_valid !== 4'b1111 || bus_a.occupancy !== 3'd4) begin
            errors++; $display("FAIL rp_full: got sv=%b occ=%0d want 1111/4", bus_a.stage_valid, bus_a.occupancy); end
        checks++; if (bus_a.bubble_cnt !== 16'd1 || bus_a.flush_cnt !== 16'd1) begin
            errors++; $display("FAIL rp_precnt: got b=%0d f=%0d want 1/1", bus_a.bubble_cnt, bus_a.flush_cnt); end
        reset = 1; bus_a.stall = 1; bus_a.flush = 1;
        tick();
        reset = 0; idle();
        checks++; if (bus_a.stage_valid !== 4'b0000 || bus_a.occupancy !== 3'd0 || bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL rp_state: got sv=%b occ=%0d ov=%b want 0000/0/0", bus_a.stage_valid, bus_a.occupancy, bus_a.out_valid); end
        checks++; if (bus_a.bubble_cnt !== 16'd0 || bus_a.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL rp_cnt: got b=%0d f=%0d want 0/0", bus_a.bubble_cnt, bus_a.flush_cnt); end
    endtask

    initial begin
        idle();
        tick();
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_flush_stall();
        test_forwarding();
        test_saturate();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of STAGES pipeline registers. It replaces the hand-coded per-stage buffers with one generic block that has uniform valid/stall/flush semantics.
- Each stage carries valid, payload, destination register and write-enable.
- Built-in youngest-first forwarding lookup for two source registers.
- Occupancy plus saturating bubble/flush performance counters.
- Instantiated between decode and writeback in the next-generation core.

Parameters:
- DATA_W, 32, payload width; forwarded data is the full payload.
- RD_W, 5, destination register index width.
- STAGES, 4, number of register stages; legal range 2..16.
- HOLD, 1, stall holds stages 0..HOLD-1 and injects a bubble at stage HOLD; legal range 1..STAGES-1.
- FLUSH, 2, flush clears stages 0..FLUSH-1; legal range 1..STAGES-1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a new entry is presented to stage 0.
- in_payload  in  DATA_W  entry payload.
- in_rd  in  RD_W  entry destination register.
- in_wen  in  1  entry writes a register.
- stall  in  1  hold the young stages and insert a bubble (load-use style).
- flush  in  1  squash the young stages (taken branch style).
- fwd_rs1, fwd_rs2  in  RD_W  source registers to look up.
- fwd1_hit, fwd2_hit  out  1  a match was found.
- fwd1_data, fwd2_data  out  DATA_W  payload of the matching stage.
- fwd1_stage, fwd2_stage  out  $clog2(STAGES)  index of the matching stage.
- out_valid, out_payload, out_rd, out_wen  out  1/DATA_W/RD_W/1  contents of stage STAGES-1.
- stage_valid  out  STAGES  valid bit of every stage; bit 0 is the youngest.
- occupancy  out  $clog2(STAGES+1)  number of set bits in stage_valid.
- bubble_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Stage 0 is the youngest; stage STAGES-1 is the oldest and drives out_*.
- Bubble: valid=0, wen=0, payload=0, rd=0.
- Reset: all stages become bubbles and both counters go to 0.
  - Reset has priority over stall and flush.
  - Outputs are 0 the cycle after reset is sampled, including fwd_*_hit, occupancy and stage_valid.
- Normal cycle (stall=0, flush=0):
  - Stage 0 captures in_*; a stage's valid bit equals in_valid, so in_valid=0 loads a bubble.
  - Stage k captures stage k-1.
  - Latency from in_* to out_* is STAGES edges.
  - Oldest contents are dropped; there is no backpressure from the output.
- Stall (stall=1, flush=0):
  - Stages 0..HOLD-1 retain their contents; in_* is ignored and upstream must hold it.
  - Stage HOLD loads a bubble.
  - Stages above HOLD shift normally.
  - bubble_cnt increments.
- Flush (flush=1):
  - Stages 0..FLUSH-1 load bubbles and in_* is discarded.
  - Stage FLUSH captures the pre-edge contents of stage FLUSH-1.
  - Higher stages shift normally.
  - stall is ignored in a flush cycle.
  - flush_cnt increments; bubble_cnt does not.
- Counters saturate at all-ones and never wrap.
- Forwarding (combinational from the stage registers):
  - Candidate stage: valid=1, wen=1, rd==fwd_rs, and fwd_rs!=0.
  - The lowest-index (youngest) candidate wins.
  - On a miss: hit=0, data=0, stage=0.
  - Register 0 never hits, even if a stage holds rd=0 with wen=1.
- Occupancy: combinational popcount of stage_valid; no registered lag.
- All outputs are driven from registers or from combinational logic over registers; there is no combinational path from in_*, stall or flush to any output.

Test Plan:
- Reset, then inject payload=0x11, rd=3, wen=1 with in_valid=1 for one cycle, followed by in_valid=0 (STAGES=4) → out_valid=1, out_payload=0x11, out_rd=3 exactly after the 4th edge; occupancy reads 1 during edges 1..4 and 0 after edge 5.
- Stage0=X (0x22), stage1=Y (0x33), stall=1 for one edge → stage0=X, stage1=bubble, stage2=Y, bubble_cnt=1; in_* presented in that cycle is not captured.
- Stage0=A, stage1=B, stage2=C, flush=1 and stall=1 together → stage0=0, stage1=0, stage2=B, stage3=C, flush_cnt=1, bubble_cnt=0.
- Stage1={rd=5, 0xAA, wen=1}, stage2={rd=5, 0xBB, wen=1}, stage0={rd=0, wen=1}, fwd_rs1=5, fwd_rs2=0 → fwd1_hit=1, fwd1_data=0xAA, fwd1_stage=1; fwd2_hit=0, fwd2_data=0. Then clear stage1 wen → fwd1 returns 0xBB from stage 2.
- CNT_W=2, stall held for 5 edges → bubble_cnt sequence 1, 2, 3, 3, 3.
- Fill all stages valid, assert reset for one edge concurrently with stall=1 and flush=1 → stage_valid=0, occupancy=0, bubble_cnt=0, flush_cnt=0, out_valid=0.
